// File: rtl/shift_reg_universal_if.sv
// Bus bundle for shift_reg_universal: mode/data inputs, register contents and sequencer status.
// Optional flag signals carry and zero exist only when SHREG_FLAGS_EN is defined.
interface shift_reg_universal_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    // Handshake: start is sampled only while busy is low; a sequenced op then holds busy
    // high for amt cycles and signals completion with a one-cycle done pulse (amt=0 gives
    // done on the next cycle with busy never rising). start may be re-asserted in the done cycle.
    logic [2:0]       op;
    logic             start;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] p;
    logic             sil;
    logic             sir;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             state_dbg;
`ifdef SHREG_FLAGS_EN
    logic             carry;
    logic             zero;
`endif

    modport master (
        output op, start, amt, p, sil, sir,
        input  q, busy, done, state_dbg
`ifdef SHREG_FLAGS_EN
        , input carry, zero
`endif
    );

    modport slave (
        input  op, start, amt, p, sil, sir,
        output q, busy, done, state_dbg
`ifdef SHREG_FLAGS_EN
        , output carry, zero
`endif
    );
endinterface

// File: rtl/shift_reg_universal.sv
// WIDTH-bit universal shift register: 194-style single-step modes plus sequenced LSR/LSL/ASR/ROR,
// one bit per clock. Defining SHREG_FLAGS_EN adds the carry and zero flag outputs.
module shift_reg_universal #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input logic                  clk,
    input logic                  clear,
    shift_reg_universal_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
`ifdef SHREG_FLAGS_EN
    logic             carry_q, carry_d;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
`ifdef SHREG_FLAGS_EN
            carry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            q_q     <= q_d;
            done_q  <= done_d;
`ifdef SHREG_FLAGS_EN
            carry_q <= carry_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        q_d     = q_q;
        done_d  = 1'b0;
`ifdef SHREG_FLAGS_EN
        carry_d = carry_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.op[2]) begin
                    // Legacy 194 modes act on every edge and ignore start/amt.
                    case (bus.op[1:0])
                        2'b01: begin
                            q_d = {bus.sir, q_q[WIDTH-1:1]};
`ifdef SHREG_FLAGS_EN
                            carry_d = q_q[0];
`endif
                        end
                        2'b10: begin
                            q_d = {q_q[WIDTH-2:0], bus.sil};
`ifdef SHREG_FLAGS_EN
                            carry_d = q_q[WIDTH-1];
`endif
                        end
                        2'b11:   q_d = bus.p;
                        default: q_d = q_q;
                    endcase
                end else if (bus.start) begin
                    op_d = bus.op[1:0];
                    if (bus.amt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        count_d = bus.amt;
                    end
                end
            end
            RUN: begin
                // op_q holds op[1:0] of the latched sequenced op: 00 LSR, 01 LSL, 10 ASR, 11 ROR.
                case (op_q)
                    2'b00:   q_d = {1'b0, q_q[WIDTH-1:1]};
                    2'b01:   q_d = {q_q[WIDTH-2:0], 1'b0};
                    2'b10:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    default: q_d = {q_q[0], q_q[WIDTH-1:1]};
                endcase
`ifdef SHREG_FLAGS_EN
                carry_d = (op_q == 2'b01) ? q_q[WIDTH-1] : q_q[0];
`endif
                count_d = count_q - 1'b1;
                if (count_q == AMT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.q         = q_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.state_dbg = (state_q == RUN);
`ifdef SHREG_FLAGS_EN
    assign bus.carry     = carry_q;
    assign bus.zero      = (q_q == '0);
`endif
endmodule
